// File: rtl/i2s_dac_tx_mono.sv
// i2s_dac_tx_mono
// Mono I2S transmitter (bus master) for an external DAC/amplifier. Samples are
// accepted on a valid/ready stream into a 2-entry FIFO, then serialised MSB
// first onto both the left and right halves of a 64-slot I2S frame. BCLK and
// WS are derived here from the system clock.
// Optional build macro: I2S_DAC_TX_UNDERRUN_CNT_EN adds a saturating 16-bit
// counter of frame starts that found the FIFO empty (port o_underrun).
module i2s_dac_tx_mono #(
   parameter int DW       = 18,
   parameter int HALF_DIV = 20
) (
   input  logic          clk,
   input  logic          RST,
   input  logic [DW-1:0] i_data,
   input  logic          i_vld,
   output logic          o_rdy,
   output logic          o_bclk,
   output logic          o_ws,
   output logic          o_sdata,
   output logic          o_frame
`ifdef I2S_DAC_TX_UNDERRUN_CNT_EN
   ,
   output logic [15:0]   o_underrun
`endif
);

   localparam int              DivW    = $clog2(HALF_DIV);
   localparam logic [DivW-1:0] DivLast = DivW'(HALF_DIV - 1);

   logic [DivW-1:0] divCnt_q, divCnt_d;
   logic            bclk_q, bclk_d;
   logic [5:0]      bitCnt_q, bitCnt_d;
   logic            ws_q, ws_d;
   logic            sdata_q, sdata_d;
   logic            frame_q, frame_d;
   logic            rdy_q, rdy_d;
   logic [1:0]      count_q, count_d;
   logic [DW-1:0]   mem0_q, mem0_d;
   logic [DW-1:0]   mem1_q, mem1_d;
   logic [DW-1:0]   outReg_q, outReg_d;

   logic divWrap;
   logic fallEvt;
   logic frameStart;
   logic wrEn;
   logic popEn;

   // A falling BCLK edge is the half-period wrap while BCLK is high; the frame
   // boundary is the falling edge that takes the slot counter from 63 back to 0.
   assign divWrap    = (divCnt_q == DivLast);
   assign fallEvt    = divWrap && bclk_q;
   assign frameStart = fallEvt && (bitCnt_q == 6'd63);
   assign wrEn       = i_vld && rdy_q;
   assign popEn      = frameStart && (count_q != 2'd0);

   // Next-state logic for the clock divider, slot counter, FIFO and serial output.
   always_comb begin
      divCnt_d = divWrap ? '0 : divCnt_q + 1'b1;
      bclk_d   = divWrap ? ~bclk_q : bclk_q;
      bitCnt_d = bitCnt_q;
      ws_d     = ws_q;
      sdata_d  = sdata_q;
      frame_d  = frameStart;
      mem0_d   = mem0_q;
      mem1_d   = mem1_q;
      count_d  = count_q;
      outReg_d = outReg_q;

      // Write and frame-start pop can coincide. With an empty FIFO the pop is
      // suppressed (popEn is low) so only the write lands. Both at once is only
      // reachable with one entry held, since a write needs room and a pop needs
      // data: the old head leaves and the new sample becomes head.
      case ({wrEn, popEn})
         2'b10: begin
            if (count_q == 2'd0) begin
               mem0_d = i_data;
            end else begin
               mem1_d = i_data;
            end
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            outReg_d = mem0_q;
            mem0_d   = mem1_q;
            count_d  = count_q - 2'd1;
         end
         2'b11: begin
            outReg_d = mem0_q;
            mem0_d   = i_data;
         end
         default: begin
         end
      endcase

      rdy_d = (count_d != 2'd2);

      // Slot k of each half carries out_reg[DW-k] for k=1..DW; slot 0 is the
      // one-bit I2S delay after the WS edge and slots past DW are zero padding.
      if (fallEvt) begin
         bitCnt_d = bitCnt_q + 6'd1;
         ws_d     = bitCnt_d[5];
         sdata_d  = 1'b0;
         for (int k = 1; k <= DW; k++) begin
            if (bitCnt_d[4:0] == 5'(k)) begin
               sdata_d = outReg_d[DW-k];
            end
         end
      end
   end

   // Register all state; reset discards buffered samples and restarts the frame.
   always_ff @(posedge clk) begin
      if (RST) begin
         divCnt_q <= '0;
         bclk_q   <= 1'b0;
         bitCnt_q <= '0;
         ws_q     <= 1'b0;
         sdata_q  <= 1'b0;
         frame_q  <= 1'b0;
         rdy_q    <= 1'b1;
         count_q  <= '0;
         mem0_q   <= '0;
         mem1_q   <= '0;
         outReg_q <= '0;
      end else begin
         divCnt_q <= divCnt_d;
         bclk_q   <= bclk_d;
         bitCnt_q <= bitCnt_d;
         ws_q     <= ws_d;
         sdata_q  <= sdata_d;
         frame_q  <= frame_d;
         rdy_q    <= rdy_d;
         count_q  <= count_d;
         mem0_q   <= mem0_d;
         mem1_q   <= mem1_d;
         outReg_q <= outReg_d;
      end
   end

   assign o_rdy   = rdy_q;
   assign o_bclk  = bclk_q;
   assign o_ws    = ws_q;
   assign o_sdata = sdata_q;
   assign o_frame = frame_q;

`ifdef I2S_DAC_TX_UNDERRUN_CNT_EN
   logic [15:0] underrun_q, underrun_d;

   // Count frame starts that found nothing to pop, holding at the maximum.
   always_comb begin
      underrun_d = underrun_q;
      if (frameStart && (count_q == 2'd0) && (underrun_q != 16'hFFFF)) begin
         underrun_d = underrun_q + 16'd1;
      end
   end

   // Underrun counter register.
   always_ff @(posedge clk) begin
      if (RST) begin
         underrun_q <= '0;
      end else begin
         underrun_q <= underrun_d;
      end
   end

   assign o_underrun = underrun_q;
`endif

endmodule
